mem_stage: RTL and testbench

- Fourth stage of the five-stage LoongArch pipeline, between exe_stage and wb_stage.
- Registers the EXE bus and finalizes the result: load-data extraction from data SRAM or multiplier word select.
- Propagates exception/CSR/ertn info, forwards its result to ID, and cancels younger stores in EXE.
- Holds SRAM read data across WB back-pressure.

---
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage of the five-stage LoongArch pipeline: registers the EXE bus, extracts
// load data or selects the multiplier word, and forwards results. Optional: MS_STALL_CNT_EN.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 162,
  parameter int MS_TO_WS_BUS_WD = 156,
  parameter int EXC_NUM         = 6
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [64:0]                es_mul_res_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [37:0]                ms_fwd_bus,
  output logic [15:0]                ms_csr_blk_bus,
  output logic                       ms_to_es_st_cancel,
  input  logic                       wb_exc,
  input  logic                       wb_ertn,
  output logic [31:0]                ms_stall_cnt
);

  logic                       r_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_es_bus;
  logic [64:0]                r_mul_bus;
  logic [31:0]                r_rdata_hold;
  logic                       r_rdata_hold_v;

  logic                       w_flush;
  logic                       w_csr_we;
  logic [13:0]                w_csr_wnum;
  logic [31:0]                w_csr_wmask;
  logic [31:0]                w_csr_wdata;
  logic                       w_inst_ertn;
  logic [EXC_NUM-1:0]         w_exc_flgs;
  logic                       w_res_from_mul;
  logic [4:0]                 w_load_op;
  logic                       w_gr_we;
  logic                       w_gr_we_out;
  logic [4:0]                 w_dest;
  logic [31:0]                w_result;
  logic [31:0]                w_pc;
  logic [31:0]                w_rdata;
  logic [15:0]                w_half;
  logic [7:0]                 w_byte;
  logic [31:0]                w_load_data;
  logic [31:0]                w_final_result;

  assign {w_csr_we, w_csr_wnum, w_csr_wmask, w_csr_wdata, w_inst_ertn, w_exc_flgs,
          w_res_from_mul, w_load_op, w_gr_we, w_dest, w_result, w_pc} = r_es_bus;

  assign w_flush        = wb_exc | wb_ertn;
  assign ms_allowin     = !r_ms_valid || ws_allowin;
  assign ms_to_ws_valid = r_ms_valid;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ms_valid <= 1'b0;
    end else if (w_flush) begin
      r_ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      r_ms_valid <= es_to_ms_valid;
    end
  end

  // NOTE: payload registers carry no reset; r_ms_valid qualifies every use of them.
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      r_es_bus  <= es_to_ms_bus;
      r_mul_bus <= es_mul_res_bus;
    end
  end

  // SRAM data is only live for one cycle; keep it while WB stalls the instruction.
  always_ff @(posedge clk) begin
    if (!resetn || w_flush) begin
      r_rdata_hold_v <= 1'b0;
    end else if (r_ms_valid && ws_allowin) begin
      r_rdata_hold_v <= 1'b0;
    end else if (r_ms_valid && !ws_allowin && !r_rdata_hold_v) begin
      r_rdata_hold_v <= 1'b1;
      r_rdata_hold   <= data_sram_rdata;
    end
  end

  assign w_rdata = r_rdata_hold_v ? r_rdata_hold : data_sram_rdata;
  assign w_half  = w_result[1] ? w_rdata[31:16] : w_rdata[15:0];

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    w_byte = w_rdata[7:0];
    case (w_result[1:0])
      2'd1:    w_byte = w_rdata[15:8];
      2'd2:    w_byte = w_rdata[23:16];
      2'd3:    w_byte = w_rdata[31:24];
      default: w_byte = w_rdata[7:0];
    endcase
  end

  always_comb begin
    w_load_data = w_rdata;
    if (w_load_op[1])      w_load_data = {16'h0, w_half};
    else if (w_load_op[2]) w_load_data = {{16{w_half[15]}}, w_half};
    else if (w_load_op[3]) w_load_data = {24'h0, w_byte};
    else if (w_load_op[4]) w_load_data = {{24{w_byte[7]}}, w_byte};
  end

  always_comb begin
    w_final_result = w_result;
    if (|w_load_op)          w_final_result = w_load_data;
    else if (w_res_from_mul) w_final_result = r_mul_bus[64] ? r_mul_bus[63:32] : r_mul_bus[31:0];
  end

  // A faulting instruction must not write the register file.
  assign w_gr_we_out = w_gr_we && !(|w_exc_flgs);

  assign ms_to_ws_bus = {w_csr_we, w_csr_wnum, w_csr_wmask, w_csr_wdata, w_inst_ertn,
                         w_exc_flgs, w_gr_we_out, w_dest, w_final_result, w_pc};

  assign ms_fwd_bus         = {w_gr_we_out && r_ms_valid, w_dest, w_final_result};
  assign ms_csr_blk_bus     = {w_csr_we && r_ms_valid, w_inst_ertn && r_ms_valid, w_csr_wnum};
  assign ms_to_es_st_cancel = r_ms_valid && ((|w_exc_flgs) || w_inst_ertn);

`ifdef MS_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stall_cnt <= 32'h0;
    end else if (r_ms_valid && !ws_allowin) begin
      r_stall_cnt <= r_stall_cnt + 32'h1;
    end
  end

  assign ms_stall_cnt = r_stall_cnt;
`else
  assign ms_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: load extraction, read-data hold,
// multiplier select, exception/ertn paths, flush and reset.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [161:0] es_to_ms_bus;
  logic [64:0]  es_mul_res_bus;
  logic [31:0]  data_sram_rdata;
  logic         ms_to_ws_valid;
  logic [155:0] ms_to_ws_bus;
  logic [37:0]  ms_fwd_bus;
  logic [15:0]  ms_csr_blk_bus;
  logic         ms_to_es_st_cancel;
  logic         wb_exc;
  logic         wb_ertn;
  logic [31:0]  ms_stall_cnt;

  int errors = 0;
  int checks = 0;

  mem_stage dut (
    .clk                (clk),
    .resetn             (resetn),
    .ws_allowin         (ws_allowin),
    .ms_allowin         (ms_allowin),
    .es_to_ms_valid     (es_to_ms_valid),
    .es_to_ms_bus       (es_to_ms_bus),
    .es_mul_res_bus     (es_mul_res_bus),
    .data_sram_rdata    (data_sram_rdata),
    .ms_to_ws_valid     (ms_to_ws_valid),
    .ms_to_ws_bus       (ms_to_ws_bus),
    .ms_fwd_bus         (ms_fwd_bus),
    .ms_csr_blk_bus     (ms_csr_blk_bus),
    .ms_to_es_st_cancel (ms_to_es_st_cancel),
    .wb_exc             (wb_exc),
    .wb_ertn            (wb_ertn),
    .ms_stall_cnt       (ms_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [161:0] mk_bus(input logic csr_we, input logic [13:0] wnum,
                                          input logic ertn, input logic [5:0] exc,
                                          input logic rfm, input logic [4:0] lop,
                                          input logic gr_we, input logic [4:0] dest,
                                          input logic [31:0] result, input logic [31:0] pc);
    return {csr_we, wnum, 32'hFFFF_0000, 32'hA5A5_5A5A, ertn, exc, rfm, lop, gr_we, dest,
            result, pc};
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge; combinational checks follow.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn          = 1'b0;
    ws_allowin      = 1'b1;
    es_to_ms_valid  = 1'b0;
    es_to_ms_bus    = '0;
    es_mul_res_bus  = '0;
    data_sram_rdata = '0;
    wb_exc          = 1'b0;
    wb_ertn         = 1'b0;
    step();
    step();
    check("rst_valid",     ms_to_ws_valid, 0);
    check("rst_allowin",   ms_allowin, 1);
    check("rst_fwd",       ms_fwd_bus[37], 0);
    check("rst_csr_blk",   ms_csr_blk_bus[15:14], 0);
    check("rst_cancel",    ms_to_es_st_cancel, 0);
    check("rst_stall_cnt", ms_stall_cnt, 0);

    // ld.b at offset 3
    resetn         = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(0, 14'h0, 0, 6'h0, 0, 5'b10000, 1, 5'd5, 32'h1003, 32'h1C00_0000);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h80FF_1234;
    #1;
    check("ldb_valid",  ms_to_ws_valid, 1);
    check("ldb_result", ms_to_ws_bus[63:32], 64'hFFFF_FF80);
    check("ldb_fwd",    ms_fwd_bus, {1'b1, 5'd5, 32'hFFFF_FF80});

    // ld.hu upper half
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(0, 14'h0, 0, 6'h0, 0, 5'b00010, 1, 5'd6, 32'h2002, 32'h1C00_0004);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'hBEEF_0001;
    #1;
    check("ldhu_result", ms_to_ws_bus[63:32], 64'h0000_BEEF);

    // ld.w held for three stalled cycles while SRAM data changes
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(0, 14'h0, 0, 6'h0, 0, 5'b00001, 1, 5'd7, 32'h3000, 32'h1C00_0008);
    step();
    es_to_ms_valid  = 1'b0;
    ws_allowin      = 1'b0;
    data_sram_rdata = 32'h1234_5678;
    #1;
    check("ldw_first", ms_to_ws_bus[63:32], 64'h1234_5678);
    check("ldw_allowin_stall", ms_allowin, 0);
    step();
    data_sram_rdata = 32'hDEAD_DEAD;
    #1;
    check("ldw_hold1", ms_to_ws_bus[63:32], 64'h1234_5678);
    step();
    step();
    ws_allowin = 1'b1;
    #1;
    check("ldw_release_valid",  ms_to_ws_valid, 1);
    check("ldw_release_result", ms_to_ws_bus[63:32], 64'h1234_5678);
`ifdef MS_STALL_CNT_EN
    check("stall_cnt_3", ms_stall_cnt, 3);
`else
    check("stall_cnt_off", ms_stall_cnt, 0);
`endif
    step();
    check("ldw_left", ms_to_ws_valid, 0);

    // next load must use live data, not the old hold
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(0, 14'h0, 0, 6'h0, 0, 5'b00001, 1, 5'd8, 32'h3004, 32'h1C00_000C);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'hCAFE_BABE;
    #1;
    check("no_stale_hold", ms_to_ws_bus[63:32], 64'hCAFE_BABE);

    // mulh / mul word select, back-to-back, then plain ALU result
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(0, 14'h0, 0, 6'h0, 1, 5'b00000, 1, 5'd9, 32'h5555_5555, 32'h1C00_0010);
    es_mul_res_bus = {1'b1, 64'h0000_0001_FFFF_FFFE};
    step();
    check("mul_hi", ms_to_ws_bus[63:32], 64'h0000_0001);
    es_mul_res_bus = {1'b0, 64'h0000_0001_FFFF_FFFE};
    step();
    check("mul_lo", ms_to_ws_bus[63:32], 64'hFFFF_FFFE);
    es_to_ms_bus = mk_bus(0, 14'h0, 0, 6'h0, 0, 5'b00000, 1, 5'd10, 32'h1234_ABCD, 32'h1C00_0014);
    step();
    check("alu_result", ms_to_ws_bus[63:32], 64'h1234_ABCD);
    check("alu_pc",     ms_to_ws_bus[31:0], 64'h1C00_0014);

    // exception: gr_we suppressed, store cancel raised, then WB flush
    es_to_ms_bus = mk_bus(0, 14'h0, 0, 6'b000100, 0, 5'b00000, 1, 5'd11, 32'h0, 32'h1C00_0018);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    check("exc_cancel",  ms_to_es_st_cancel, 1);
    check("exc_gr_we",   ms_to_ws_bus[69], 0);
    check("exc_flgs",    ms_to_ws_bus[75:70], 6'b000100);
    check("exc_fwd_we",  ms_fwd_bus[37], 0);
    wb_exc = 1'b1;
    step();
    wb_exc = 1'b0;
    #1;
    check("flush_valid",  ms_to_ws_valid, 0);
    check("flush_cancel", ms_to_es_st_cancel, 0);

    // csr write + ertn: block bus and store cancel
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(1, 14'h0123, 1, 6'h0, 0, 5'b00000, 0, 5'd0, 32'h0, 32'h1C00_001C);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    check("csr_blk",     ms_csr_blk_bus, {1'b1, 1'b1, 14'h0123});
    check("ertn_cancel", ms_to_es_st_cancel, 1);
    step();

    // reset while a held load is resident
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(0, 14'h0, 0, 6'h0, 0, 5'b00001, 1, 5'd12, 32'h4000, 32'h1C00_0020);
    step();
    es_to_ms_valid  = 1'b0;
    ws_allowin      = 1'b0;
    data_sram_rdata = 32'h1111_1111;
    step();
    resetn = 1'b0;
    step();
    check("rst2_valid",     ms_to_ws_valid, 0);
    check("rst2_allowin",   ms_allowin, 1);
    check("rst2_stall_cnt", ms_stall_cnt, 0);
    resetn         = 1'b1;
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(0, 14'h0, 0, 6'h0, 0, 5'b00001, 1, 5'd13, 32'h4004, 32'h1C00_0024);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h2222_2222;
    #1;
    check("rst2_hold_cleared", ms_to_ws_bus[63:32], 64'h2222_2222);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
